// File: rtl/cdb_broadcast_pkg.sv
// Shared core definitions for the completion data bus: default widths and queue depth,
// the completion-queue entry layout and a small lane-count helper.
package cdb_broadcast_pkg;

    localparam int unsigned CORE_N_WAY    = 2;
    localparam int unsigned CORE_CDB_BITS = 6;
    localparam int unsigned CORE_XLEN     = 32;
    localparam int unsigned CORE_CQ_DEPTH = 8;

    typedef struct packed {
        logic [CORE_CDB_BITS-1:0] tag;
        logic [CORE_XLEN-1:0]     data;
    } cq_entry_t;

    function automatic int unsigned lanes_presented(input int unsigned count,
                                                    input int unsigned n_way);
        return (count < n_way) ? count : n_way;
    endfunction

endpackage

// File: rtl/cq_mpfifo.sv
// Multi-port circular completion queue: up to N_WAY writes and N_WAY reads per cycle,
// power-of-two depth so head/tail wrap naturally.
module cq_mpfifo
    import cdb_broadcast_pkg::*;
#(
    parameter int unsigned N_WAY = CORE_N_WAY,
    parameter int unsigned WIDTH = CORE_CDB_BITS + CORE_XLEN,
    parameter int unsigned DEPTH = CORE_CQ_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(N_WAY + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [CW-1:0]                push_cnt,
    input  logic [N_WAY-1:0][WIDTH-1:0]  push_data,
    input  logic [CW-1:0]                pop_cnt,
    output logic [N_WAY-1:0][WIDTH-1:0]  rd_data,
    output logic [AW:0]                  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_cnt);
            tail  <= tail + AW'(push_cnt);
            count <= count + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
        end
    end

    // Storage needs no reset: validity is carried entirely by head/count.
    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int unsigned i = 0; i < N_WAY; i++) begin
                if (i < 32'(push_cnt))
                    mem[tail + AW'(i)] <= push_data[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N_WAY; i++)
            rd_data[i] = mem[head + AW'(i)];
    end

endmodule

// File: rtl/cdb_broadcast.sv
// Completion data bus broadcaster: compacts execute results into the completion queue
// and broadcasts the oldest entries to ROB/RS and the register file write ports.
module cdb_broadcast
    import cdb_broadcast_pkg::*;
#(
    parameter int unsigned N_WAY    = CORE_N_WAY,
    parameter int unsigned CDB_BITS = CORE_CDB_BITS,
    parameter int unsigned XLEN     = CORE_XLEN,
    parameter int unsigned CQ_DEPTH = CORE_CQ_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_WAY-1:0]                 ex_valid,
    input  logic [N_WAY-1:0][CDB_BITS-1:0]   ex_dest_tag,
    input  logic [N_WAY-1:0][XLEN-1:0]       ex_result,
    output logic                             ex_ready,
    input  logic                             cdb_hold,
    input  logic                             flush,
    output logic [N_WAY-1:0][CDB_BITS-1:0]   complete_dest_tag,
    output logic [N_WAY-1:0]                 wr_en,
    output logic [N_WAY-1:0][CDB_BITS-1:0]   wr_idx,
    output logic [N_WAY-1:0][XLEN-1:0]       wr_data,
    output logic [$clog2(CQ_DEPTH):0]        cq_count
);

    localparam int unsigned CW   = $clog2(N_WAY + 1);
    localparam int unsigned CNTW = $clog2(CQ_DEPTH) + 1;

    typedef struct packed {
        logic [CDB_BITS-1:0] tag;
        logic [XLEN-1:0]     data;
    } lane_entry_t;

    lane_entry_t [N_WAY-1:0] push_data;
    lane_entry_t [N_WAY-1:0] rd_data;
    logic [CW-1:0]           push_cnt;
    logic [CW-1:0]           pop_cnt;
    int unsigned             acc_cnt;
    int unsigned             n_pres;

    // Ready looks only at registered occupancy, never at this cycle's inputs.
    assign ex_ready = (cq_count <= CNTW'(CQ_DEPTH - N_WAY));

    // Accepted lanes are packed toward slot 0 in ascending lane order.
    always_comb begin
        push_data = '0;
        acc_cnt   = 0;
        if (ex_ready && !flush) begin
            for (int unsigned i = 0; i < N_WAY; i++) begin
                if (ex_valid[i] && (ex_dest_tag[i] != '0)) begin
                    for (int unsigned j = 0; j < N_WAY; j++) begin
                        if (j == acc_cnt)
                            push_data[j] = '{tag: ex_dest_tag[i], data: ex_result[i]};
                    end
                    acc_cnt = acc_cnt + 1;
                end
            end
        end
        push_cnt = CW'(acc_cnt);
    end

    always_comb begin
        n_pres = 0;
        if (!flush && !cdb_hold)
            n_pres = lanes_presented(32'(cq_count), N_WAY);
        pop_cnt           = CW'(n_pres);
        complete_dest_tag = '0;
        wr_en             = '0;
        wr_idx            = '0;
        wr_data           = '0;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            if (i < n_pres) begin
                complete_dest_tag[i] = rd_data[i].tag;
                wr_idx[i]            = rd_data[i].tag;
                wr_en[i]             = 1'b1;
                wr_data[i]           = rd_data[i].data;
            end
        end
    end

    cq_mpfifo #(
        .N_WAY (N_WAY),
        .WIDTH (CDB_BITS + XLEN),
        .DEPTH (CQ_DEPTH)
    ) u_cq (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .rd_data   (rd_data),
        .count     (cq_count)
    );

endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed bench for cdb_broadcast: reset, single/dual enqueue, hold fill, ready boundary,
// wrap-around ordering, flush and mid-burst asynchronous reset.
module tb_cdb_broadcast;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        ex_valid = '0;
    logic [1:0][5:0]   ex_dest_tag = '0;
    logic [1:0][31:0]  ex_result = '0;
    logic              ex_ready;
    logic              cdb_hold = 1'b0;
    logic              flush = 1'b0;
    logic [1:0][5:0]   complete_dest_tag;
    logic [1:0]        wr_en;
    logic [1:0][5:0]   wr_idx;
    logic [1:0][31:0]  wr_data;
    logic [3:0]        cq_count;

    int checks = 0;
    int errors = 0;

    cdb_broadcast #(
        .N_WAY    (2),
        .CDB_BITS (6),
        .XLEN     (32),
        .CQ_DEPTH (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_dest_tag       (ex_dest_tag),
        .ex_result         (ex_result),
        .ex_ready          (ex_ready),
        .cdb_hold          (cdb_hold),
        .flush             (flush),
        .complete_dest_tag (complete_dest_tag),
        .wr_en             (wr_en),
        .wr_idx            (wr_idx),
        .wr_data           (wr_data),
        .cq_count          (cq_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid    = '0;
        ex_dest_tag = '0;
        ex_result   = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        #12;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ex_ready); end
        checks++; if (cq_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cq_count); end
        checks++; if (wr_en !== 2'b00 || complete_dest_tag !== 12'd0 || wr_data !== 64'd0 || wr_idx !== 12'd0) begin
            errors++; $display("FAIL reset_outputs: wr_en=%b tags=%h data=%h idx=%h expected all zero", wr_en, complete_dest_tag, wr_data, wr_idx); end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pair;
        ex_valid       = 2'b11;
        ex_dest_tag[0] = 6'd5;  ex_result[0] = 32'h11;
        ex_dest_tag[1] = 6'd9;  ex_result[1] = 32'h22;
        #1;
        checks++; if (wr_en !== 2'b00) begin errors++; $display("FAIL pair_no_bypass: wr_en got %b expected 00", wr_en); end
        tick();
        idle_inputs();
        #1;
        checks++; if (cq_count !== 4'd2) begin errors++; $display("FAIL pair_count: got %0d expected 2", cq_count); end
        checks++; if (complete_dest_tag !== {6'd9, 6'd5}) begin errors++; $display("FAIL pair_tags: got %h expected %h", complete_dest_tag, {6'd9, 6'd5}); end
        checks++; if (wr_idx !== {6'd9, 6'd5}) begin errors++; $display("FAIL pair_idx: got %h expected %h", wr_idx, {6'd9, 6'd5}); end
        checks++; if (wr_en !== 2'b11) begin errors++; $display("FAIL pair_wr_en: got %b expected 11", wr_en); end
        checks++; if (wr_data[0] !== 32'h11 || wr_data[1] !== 32'h22) begin errors++; $display("FAIL pair_data: got %h/%h expected 11/22", wr_data[0], wr_data[1]); end
        tick();
        checks++; if (cq_count !== 4'd0 || wr_en !== 2'b00) begin errors++; $display("FAIL pair_drained: count=%0d wr_en=%b expected 0/00", cq_count, wr_en); end
    endtask

    task automatic test_single_lane;
        ex_valid       = 2'b10;
        ex_dest_tag[0] = 6'd0;  ex_result[0] = 32'hDEAD;
        ex_dest_tag[1] = 6'd7;  ex_result[1] = 32'h77;
        tick();
        idle_inputs();
        #1;
        checks++; if (cq_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", cq_count); end
        checks++; if (complete_dest_tag !== {6'd0, 6'd7} || wr_en !== 2'b01) begin
            errors++; $display("FAIL single_lane0: tags=%h wr_en=%b expected %h/01", complete_dest_tag, wr_en, {6'd0, 6'd7}); end
        checks++; if (wr_data[0] !== 32'h77 || wr_data[1] !== 32'h0 || wr_idx[1] !== 6'd0) begin
            errors++; $display("FAIL single_data: got %h/%h idx1=%0d expected 77/0/0", wr_data[0], wr_data[1], wr_idx[1]); end
        tick();
        ex_valid       = 2'b01;
        ex_dest_tag[0] = 6'd0;  ex_result[0] = 32'h55;
        tick();
        idle_inputs();
        #1;
        checks++; if (cq_count !== 4'd0 || wr_en !== 2'b00) begin errors++; $display("FAIL tag0_dropped: count=%0d wr_en=%b expected 0/00", cq_count, wr_en); end
    endtask

    task automatic test_hold_fill;
        logic [5:0] t0;
        logic [5:0] t1;
        cdb_hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ex_valid       = 2'b11;
            ex_dest_tag[0] = 6'(10 + 2 * c);  ex_result[0] = 32'(10 + 2 * c) << 8;
            ex_dest_tag[1] = 6'(11 + 2 * c);  ex_result[1] = 32'(11 + 2 * c) << 8;
            #1;
            checks++; if (ex_ready !== 1'b1 || wr_en !== 2'b00) begin errors++; $display("FAIL hold_fill_%0d: ready=%b wr_en=%b expected 1/00", c, ex_ready, wr_en); end
            tick();
            checks++; if (cq_count !== 4'(2 * c + 2)) begin errors++; $display("FAIL hold_count_%0d: got %0d expected %0d", c, cq_count, 2 * c + 2); end
        end
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL hold_full_ready: got %b expected 0", ex_ready); end
        ex_dest_tag[0] = 6'd30;  ex_dest_tag[1] = 6'd31;
        tick();
        checks++; if (cq_count !== 4'd8) begin errors++; $display("FAIL hold_full_ignore: got %0d expected 8", cq_count); end
        idle_inputs();
        cdb_hold = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            t0 = 6'(10 + 2 * d);
            t1 = 6'(11 + 2 * d);
            checks++; if (complete_dest_tag !== {t1, t0} || wr_en !== 2'b11 || wr_data[0] !== (32'(t0) << 8)) begin
                errors++; $display("FAIL hold_drain_%0d: tags=%h wr_en=%b data0=%h expected %h/11/%h", d, complete_dest_tag, wr_en, wr_data[0], {t1, t0}, 32'(t0) << 8); end
            tick();
            checks++; if (cq_count !== 4'(6 - 2 * d)) begin errors++; $display("FAIL hold_drain_count_%0d: got %0d expected %0d", d, cq_count, 6 - 2 * d); end
        end
    endtask

    task automatic test_ready_at_seven;
        logic [5:0] t0;
        logic [5:0] t1;
        cdb_hold = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            ex_valid       = 2'b01;
            ex_dest_tag[0] = 6'(t);
            ex_result[0]   = 32'(t);
            tick();
        end
        checks++; if (cq_count !== 4'd7 || ex_ready !== 1'b0) begin errors++; $display("FAIL seven_ready: count=%0d ready=%b expected 7/0", cq_count, ex_ready); end
        ex_dest_tag[0] = 6'd20;
        tick();
        checks++; if (cq_count !== 4'd7) begin errors++; $display("FAIL seven_ignore: got %0d expected 7", cq_count); end
        idle_inputs();
        cdb_hold = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            t0 = 6'(2 * d + 1);
            t1 = (2 * d + 2 <= 7) ? 6'(2 * d + 2) : 6'd0;
            checks++; if (complete_dest_tag !== {t1, t0} || wr_en !== {(t1 != 6'd0), 1'b1}) begin
                errors++; $display("FAIL seven_drain_%0d: tags=%h wr_en=%b expected %h/%b", d, complete_dest_tag, wr_en, {t1, t0}, {(t1 != 6'd0), 1'b1}); end
            tick();
        end
        checks++; if (cq_count !== 4'd0) begin errors++; $display("FAIL seven_empty: got %0d expected 0", cq_count); end
    endtask

    task automatic test_wrap;
        logic [5:0]  exp_tag[$];
        logic [31:0] exp_data[$];
        logic [5:0]  nxt;
        logic [5:0]  et;
        logic [31:0] ed;
        int          n;
        nxt = 6'd1;
        cdb_hold = 1'b1;
        for (int p = 0; p < 3; p++) begin
            ex_valid = 2'b11;
            for (int l = 0; l < 2; l++) begin
                ex_dest_tag[l] = nxt;
                ex_result[l]   = 32'hA5A5_0000 | 32'(nxt);
                exp_tag.push_back(nxt);
                exp_data.push_back(32'hA5A5_0000 | 32'(nxt));
                nxt = nxt + 6'd1;
            end
            tick();
        end
        idle_inputs();
        cdb_hold = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            n = (exp_tag.size() < 2) ? exp_tag.size() : 2;
            checks++; if (cq_count !== 4'(exp_tag.size())) begin errors++; $display("FAIL wrap_count_%0d: got %0d expected %0d", c, cq_count, exp_tag.size()); end
            for (int l = 0; l < 2; l++) begin
                et = (l < n) ? exp_tag[l] : 6'd0;
                ed = (l < n) ? exp_data[l] : 32'd0;
                checks++; if (complete_dest_tag[l] !== et || wr_data[l] !== ed || wr_en[l] !== (l < n)) begin
                    errors++; $display("FAIL wrap_lane_%0d_%0d: tag=%0d data=%h en=%b expected %0d/%h/%b", c, l, complete_dest_tag[l], wr_data[l], wr_en[l], et, ed, (l < n)); end
            end
            idle_inputs();
            if (c % 5 == 0) begin
                ex_valid       = 2'b10;
                ex_dest_tag[1] = nxt;
                ex_result[1]   = 32'hA5A5_0000 | 32'(nxt);
                exp_tag.push_back(nxt);
                exp_data.push_back(32'hA5A5_0000 | 32'(nxt));
                nxt = nxt + 6'd1;
            end else begin
                ex_valid = 2'b11;
                for (int l = 0; l < 2; l++) begin
                    ex_dest_tag[l] = nxt;
                    ex_result[l]   = 32'hA5A5_0000 | 32'(nxt);
                    exp_tag.push_back(nxt);
                    exp_data.push_back(32'hA5A5_0000 | 32'(nxt));
                    nxt = nxt + 6'd1;
                end
            end
            tick();
            for (int k = 0; k < n; k++) begin
                void'(exp_tag.pop_front());
                void'(exp_data.pop_front());
            end
        end
        idle_inputs();
        for (int k = 0; k < 5; k++) tick();
        checks++; if (cq_count !== 4'd0 || wr_en !== 2'b00) begin errors++; $display("FAIL wrap_drained: count=%0d wr_en=%b expected 0/00", cq_count, wr_en); end
    endtask

    task automatic test_flush;
        cdb_hold = 1'b1;
        ex_valid = 2'b11; ex_dest_tag[0] = 6'd1; ex_dest_tag[1] = 6'd2; tick();
        ex_dest_tag[0] = 6'd3; ex_dest_tag[1] = 6'd4; tick();
        ex_valid = 2'b01; ex_dest_tag[0] = 6'd5; tick();
        checks++; if (cq_count !== 4'd5) begin errors++; $display("FAIL flush_prefill: got %0d expected 5", cq_count); end
        cdb_hold = 1'b0;
        flush    = 1'b1;
        ex_valid = 2'b11;
        ex_dest_tag[0] = 6'd40; ex_result[0] = 32'h40;
        ex_dest_tag[1] = 6'd41; ex_result[1] = 32'h41;
        #1;
        checks++; if (wr_en !== 2'b00 || complete_dest_tag !== 12'd0 || wr_data !== 64'd0 || wr_idx !== 12'd0) begin
            errors++; $display("FAIL flush_outputs: wr_en=%b tags=%h data=%h expected all zero", wr_en, complete_dest_tag, wr_data); end
        tick();
        flush = 1'b0;
        idle_inputs();
        #1;
        checks++; if (cq_count !== 4'd0 || wr_en !== 2'b00) begin errors++; $display("FAIL flush_cleared: count=%0d wr_en=%b expected 0/00", cq_count, wr_en); end
        tick();
        checks++; if (cq_count !== 4'd0) begin errors++; $display("FAIL flush_discard: got %0d expected 0", cq_count); end
    endtask

    task automatic test_reset_mid;
        ex_valid = 2'b11; ex_dest_tag[0] = 6'd12; ex_dest_tag[1] = 6'd13; tick();
        ex_dest_tag[0] = 6'd14; ex_dest_tag[1] = 6'd15; tick();
        idle_inputs();
        cdb_hold = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (ex_ready !== 1'b1 || cq_count !== 4'd0) begin errors++; $display("FAIL midreset_state: ready=%b count=%0d expected 1/0", ex_ready, cq_count); end
        cdb_hold = 1'b0;
        #1;
        checks++; if (wr_en !== 2'b00 || complete_dest_tag !== 12'd0 || wr_data !== 64'd0) begin
            errors++; $display("FAIL midreset_outputs: wr_en=%b tags=%h expected zero", wr_en, complete_dest_tag); end
        #1;
        reset = 1'b1;
        tick();
        ex_valid = 2'b11; ex_dest_tag[0] = 6'd3; ex_dest_tag[1] = 6'd4;
        #1;
        checks++; if (wr_en !== 2'b00) begin errors++; $display("FAIL midreset_lost: wr_en got %b expected 00", wr_en); end
        tick();
        idle_inputs();
        #1;
        checks++; if (complete_dest_tag !== {6'd4, 6'd3} || wr_en !== 2'b11) begin
            errors++; $display("FAIL midreset_first: tags=%h wr_en=%b expected %h/11", complete_dest_tag, wr_en, {6'd4, 6'd3}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_pair();
        test_single_lane();
        test_hold_fill();
        test_ready_at_seven();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
